// File: rtl/writeback_stage_pipelined.sv
// PSRV32 writeback stage: one-entry MEM/WB register, result select, load alignment, RF write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage_pipelined #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LSB_W      = $clog2(XLEN/8)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       data_read_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [1:0]            mem_to_reg_i,
  input  logic [1:0]            load_size_i,
  input  logic                  load_unsigned_i,
  input  logic [LSB_W-1:0]      addr_lsb_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  rf_ready_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  retire_o,
  output logic [63:0]           retire_cnt_o
);

  logic                  r_occ;
  logic [XLEN-1:0]       r_data;
  logic [XLEN-1:0]       r_alu;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_imm;
  logic [1:0]            r_sel;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [LSB_W-1:0]      r_lsb;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_we;

  logic w_wr_req;
  logic w_retire;
  logic w_ready;
  logic w_capture;

  // Offset is forced to the natural alignment of the access size; D on XLEN=32 degenerates to W.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0]  data,
                                                 input logic [1:0]       size,
                                                 input logic             uns,
                                                 input logic [LSB_W-1:0] lsb);
    logic [LSB_W-1:0] off;
    logic [XLEN-1:0]  sh;
    logic             ext;
    logic [XLEN-1:0]  res;
    case (size)
      2'b00:   off = lsb;
      2'b01:   off = lsb & ~LSB_W'(1);
      2'b10:   off = lsb & ~LSB_W'(3);
      default: off = '0;
    endcase
    sh = data >> {off, 3'b000};
    case (size)
      2'b00:   ext = !uns && sh[7];
      2'b01:   ext = !uns && sh[15];
      2'b10:   ext = !uns && sh[31];
      default: ext = 1'b0;
    endcase
    res = {XLEN{ext}};
    case (size)
      2'b00:   res[7:0]  = sh[7:0];
      2'b01:   res[15:0] = sh[15:0];
      2'b10:   res[31:0] = sh[31:0];
      default: res       = sh;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] select_result(input logic [1:0]      sel,
                                                    input logic [XLEN-1:0] alu,
                                                    input logic [XLEN-1:0] ld,
                                                    input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] imm);
    case (sel)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return pc + XLEN'(4);
      default: return imm;
    endcase
  endfunction

  assign w_wr_req  = r_occ && r_we && (r_rd != '0);
  assign w_retire  = r_occ && !flush_i && !reset_i && (rf_ready_i || !w_wr_req);
  assign w_ready   = !r_occ || w_retire;
  assign w_capture = valid_i && w_ready && !flush_i;

  assign ready_o    = w_ready;
  assign retire_o   = w_retire;
  assign rf_we_o    = w_wr_req && rf_ready_i && !flush_i && !reset_i;
  assign rf_waddr_o = r_rd;
  assign rf_wdata_o = select_result(r_sel, r_alu,
                                    align_load(r_data, r_size, r_uns, r_lsb),
                                    r_pc, r_imm);

  // MEM/WB register: a retiring entry may be replaced by a new capture in the same cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_occ  <= 1'b0;
      r_data <= '0;
      r_alu  <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
      r_sel  <= '0;
      r_size <= '0;
      r_uns  <= 1'b0;
      r_lsb  <= '0;
      r_rd   <= '0;
      r_we   <= 1'b0;
    end else begin
      if (flush_i) begin
        r_occ <= 1'b0;
      end else if (w_capture) begin
        r_occ <= 1'b1;
      end else if (w_retire) begin
        r_occ <= 1'b0;
      end
      if (w_capture) begin
        r_data <= data_read_i;
        r_alu  <= alu_result_i;
        r_pc   <= pc_i;
        r_imm  <= imm_i;
        r_sel  <= mem_to_reg_i;
        r_size <= load_size_i;
        r_uns  <= load_unsigned_i;
        r_lsb  <= addr_lsb_i;
        r_rd   <= rd_addr_i;
        r_we   <= reg_write_i;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign retire_cnt_o = r_retire_cnt;
`else
  assign retire_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage_pipelined.sv
// Bench for writeback_stage_pipelined: directed scenarios then random traffic vs. a behavioural model.
module tb_writeback_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready_o;
  logic        flush;
  logic [31:0] data_rd;
  logic [31:0] alu;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [1:0]  sel;
  logic [1:0]  sz;
  logic        uns;
  logic [1:0]  lsb;
  logic [4:0]  rd;
  logic        we;
  logic        rf_ready;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        retire_o;
  logic [63:0] retire_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic        m_occ = 1'b0;
  logic [4:0]  m_rd  = '0;
  logic        m_wr  = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [63:0] m_cnt = '0;

  always #5 clk = ~clk;

  writeback_stage_pipelined #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .ready_o(ready_o), .flush_i(flush),
    .data_read_i(data_rd), .alu_result_i(alu), .pc_i(pc), .imm_i(imm),
    .mem_to_reg_i(sel), .load_size_i(sz), .load_unsigned_i(uns), .addr_lsb_i(lsb),
    .rd_addr_i(rd), .reg_write_i(we), .rf_ready_i(rf_ready), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load value by byte arithmetic: size in bytes, naturally aligned offset, two's-complement extend.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] s,
                                           input logic u, input logic [1:0] a);
    int nb;
    int off;
    logic [63:0] full, modv, v;
    nb   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off  = (int'(a) / nb) * nb;
    full = {32'd0, d} >> (8 * off);
    modv = 64'd1 << (8 * nb);
    v    = full % modv;
    if (!u && v >= (modv >> 1)) v = v - modv;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_result();
    case (sel)
      2'd0:    return alu;
      2'd1:    return ref_load(data_rd, sz, uns, lsb);
      2'd2:    return 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
      default: return imm;
    endcase
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
    return m_cnt;
`else
    return 64'd0;
`endif
  endfunction

  // One clock cycle: check outputs against the model, then advance model and DUT together.
  task automatic tick();
    logic wr_req, e_we, e_ret, e_rdy;
    logic        n_occ, n_wr;
    logic [4:0]  n_rd;
    logic [31:0] n_wdata;
    logic [63:0] n_cnt;
    #1;
    wr_req = m_occ && m_wr && (m_rd != 5'd0);
    e_we   = wr_req && rf_ready && !flush && !rst;
    e_ret  = m_occ && !flush && !rst && (rf_ready || !wr_req);
    e_rdy  = !m_occ || e_ret;
    chk("ready", 64'(ready_o), 64'(e_rdy));
    chk("rf_we", 64'(rf_we_o), 64'(e_we));
    chk("retire", 64'(retire_o), 64'(e_ret));
    chk("retire_cnt", retire_cnt_o, exp_cnt());
    if (m_occ) begin
      chk("waddr", 64'(rf_waddr_o), 64'(m_rd));
      chk("wdata", 64'(rf_wdata_o), 64'(m_wdata));
    end
    n_occ = m_occ; n_rd = m_rd; n_wr = m_wr; n_wdata = m_wdata; n_cnt = m_cnt;
    if (rst) begin
      n_occ = 1'b0;
      n_cnt = '0;
    end else begin
      if (e_ret) n_cnt = m_cnt + 64'd1;
      if (flush) n_occ = 1'b0;
      else if (valid && e_rdy) begin
        n_occ = 1'b1; n_rd = rd; n_wr = we; n_wdata = ref_result();
      end else if (e_ret) n_occ = 1'b0;
    end
    @(posedge clk);
    m_occ = n_occ; m_rd = n_rd; m_wr = n_wr; m_wdata = n_wdata; m_cnt = n_cnt;
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] p, input logic [31:0] im,
                     input logic [1:0] z, input logic u, input logic [1:0] l,
                     input logic [4:0] r, input logic w);
    valid = v; sel = s; alu = a; data_rd = d; pc = p; imm = im;
    sz = z; uns = u; lsb = l; rd = r; we = w;
  endtask

  initial begin
    logic [63:0] base;
    rst = 1'b1; flush = 1'b0; rf_ready = 1'b1;
    put(1, 2'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 5'd3, 1);
    @(posedge clk); #1;
    #1;
    chk("rst_we", 64'(rf_we_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_cnt", retire_cnt_o, 64'd0);
    tick();
    rst = 1'b0;

    // ALU write to x5
    put(1, 2'd0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 5'd5, 1);
    tick();
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    #1;
    chk("t1_we", 64'(rf_we_o), 64'd1);
    chk("t1_waddr", 64'(rf_waddr_o), 64'd5);
    chk("t1_wdata", 64'(rf_wdata_o), 64'h1234_5678);
    tick();

    // Load alignment from 0x80FF_7F01
    put(1, 2'd1, 0, 32'h80FF_7F01, 0, 0, 2'd0, 0, 2'd2, 5'd6, 1);
    tick();
    put(1, 2'd1, 0, 32'h80FF_7F01, 0, 0, 2'd0, 1, 2'd2, 5'd6, 1);
    chk("t2_lb", 64'(rf_wdata_o), 64'hFFFF_FFFF);
    tick();
    put(1, 2'd1, 0, 32'h80FF_7F01, 0, 0, 2'd1, 0, 2'd2, 5'd6, 1);
    chk("t2_lbu", 64'(rf_wdata_o), 64'h0000_00FF);
    tick();
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    chk("t2_lh", 64'(rf_wdata_o), 64'hFFFF_80FF);
    tick();

    // Write to x0 retires without a grant
    rf_ready = 1'b0;
    put(1, 2'd0, 32'h0000_0BAD, 0, 0, 0, 0, 0, 0, 5'd0, 1);
    tick();
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    #1;
    chk("t3_we", 64'(rf_we_o), 64'd0);
    chk("t3_retire", 64'(retire_o), 64'd1);
    chk("t3_ready", 64'(ready_o), 64'd1);
    tick();

    // Stall for 3 cycles, then write and capture together
    put(1, 2'd0, 32'h0000_AAAA, 0, 0, 0, 0, 0, 0, 5'd7, 1);
    tick();
    put(1, 2'd0, 32'h0000_BBBB, 0, 0, 0, 0, 0, 0, 5'd8, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_ready", 64'(ready_o), 64'd0);
      chk("t4_stall_we", 64'(rf_we_o), 64'd0);
      chk("t4_stall_wdata", 64'(rf_wdata_o), 64'h0000_AAAA);
      tick();
    end
    rf_ready = 1'b1;
    #1;
    chk("t4_grant_we", 64'(rf_we_o), 64'd1);
    chk("t4_grant_ready", 64'(ready_o), 64'd1);
    tick();
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    chk("t4_next_waddr", 64'(rf_waddr_o), 64'd8);
    chk("t4_next_wdata", 64'(rf_wdata_o), 64'h0000_BBBB);
    tick();

    // PC+4 wraps; flush kills held and incoming entries
    put(1, 2'd2, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 5'd9, 1);
    tick();
    put(1, 2'd0, 32'h55, 0, 0, 0, 0, 0, 0, 5'd10, 1);
    flush = 1'b1;
    chk("t5_pc4", 64'(rf_wdata_o), 64'd0);
    #1;
    chk("t5_flush_we", 64'(rf_we_o), 64'd0);
    chk("t5_flush_retire", 64'(retire_o), 64'd0);
    base = m_cnt;
    tick();
    flush = 1'b0;
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    #1;
    chk("t5_after_ready", 64'(ready_o), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("t5_cnt_hold", retire_cnt_o, base);
`else
    chk("t5_cnt_hold", retire_cnt_o, 64'd0);
`endif
    tick();

    // 10 back-to-back entries
    base = m_cnt;
    for (int i = 0; i < 10; i++) begin
      put(1, 2'd3, 0, 0, 0, 32'h100 + 32'(i), 0, 0, 0, 5'(11 + i), 1);
      tick();
    end
    put(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    tick();
`ifdef WB_RETIRE_CNT_EN
    chk("t6_cnt10", retire_cnt_o, base + 64'd10);
`else
    chk("t6_cnt10", retire_cnt_o, 64'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      put($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          1'($urandom_range(0, 1)));
      rf_ready = $urandom_range(0, 9) < 7;
      flush    = $urandom_range(0, 19) == 0;
      rst      = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
